// File: rtl/reg_f_arbiter.sv
// reg_f_arbiter: round-robin arbiter giving two requesters single-transaction
// access to one reg_f register file via a REQ/ACK handshake.
// Ports:
//   CLK, RST                   clock (rising edge), async active-high reset
//   REQn/WEn/ADDRn/WDATAn      requester n transaction (held until ACKn)
//   ACKn                       one-cycle completion pulse to requester n
//   RDATAn                     last read data returned to requester n
//   RF_EN/RF_SEL/RF_IN         reg_f write enable, register select, write data
//   RF_OUT                     reg_f combinational read of selected register
//   BUSY                       high while a transaction is in flight
module reg_f_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SIZE  = 9,
  localparam int unsigned AW   = $clog2(SIZE)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0,
  input  logic             WE0,
  input  logic [AW-1:0]    ADDR0,
  input  logic [WIDTH-1:0] WDATA0,
  output logic             ACK0,
  output logic [WIDTH-1:0] RDATA0,
  input  logic             REQ1,
  input  logic             WE1,
  input  logic [AW-1:0]    ADDR1,
  input  logic [WIDTH-1:0] WDATA1,
  output logic             ACK1,
  output logic [WIDTH-1:0] RDATA1,
  output logic             RF_EN,
  output logic [AW-1:0]    RF_SEL,
  output logic [WIDTH-1:0] RF_IN,
  input  logic [WIDTH-1:0] RF_OUT,
  output logic             BUSY
);

  typedef enum logic [1:0] {IDLE, XFER, ACKS} state_t;

  state_t           state, state_n;
  logic             last, last_n;
  logic             owner, owner_n;
  logic             win;
  logic             en_n;
  logic [AW-1:0]    sel_n;
  logic [WIDTH-1:0] in_n;
  logic             ack0_n, ack1_n;
  logic [WIDTH-1:0] rd0_n, rd1_n;
  logic             busy_n;

  // State and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      last   <= 1'b1;
      owner  <= 1'b0;
      RF_EN  <= 1'b0;
      RF_SEL <= '0;
      RF_IN  <= '0;
      ACK0   <= 1'b0;
      ACK1   <= 1'b0;
      RDATA0 <= '0;
      RDATA1 <= '0;
      BUSY   <= 1'b0;
    end else begin
      state  <= state_n;
      last   <= last_n;
      owner  <= owner_n;
      RF_EN  <= en_n;
      RF_SEL <= sel_n;
      RF_IN  <= in_n;
      ACK0   <= ack0_n;
      ACK1   <= ack1_n;
      RDATA0 <= rd0_n;
      RDATA1 <= rd1_n;
      BUSY   <= busy_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n = state;
    last_n  = last;
    owner_n = owner;
    win     = 1'b0;
    en_n    = RF_EN;
    sel_n   = RF_SEL;
    in_n    = RF_IN;
    ack0_n  = 1'b0;
    ack1_n  = 1'b0;
    rd0_n   = RDATA0;
    rd1_n   = RDATA1;
    unique case (state)
      IDLE: begin
        if (REQ0 || REQ1) begin
          // Under contention the requester that was not served last wins
          win     = (REQ0 && REQ1) ? ~last : REQ1;
          owner_n = win;
          sel_n   = win ? ADDR1  : ADDR0;
          in_n    = win ? WDATA1 : WDATA0;
          en_n    = win ? WE1    : WE0;
          state_n = XFER;
        end
      end
      XFER: begin
        // Read data is captured on the same edge that completes a write
        if (!RF_EN) begin
          if (owner) rd1_n = RF_OUT;
          else       rd0_n = RF_OUT;
        end
        if (owner) ack1_n = 1'b1;
        else       ack0_n = 1'b1;
        en_n    = 1'b0;
        last_n  = owner;
        state_n = ACKS;
      end
      ACKS: begin
        state_n = IDLE;
      end
      default: begin
        en_n    = 1'b0;
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_reg_f_arbiter.sv
// Scoreboard bench for reg_f_arbiter with a behavioural reg_f model.
module tb_reg_f_arbiter;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned AW    = 4;

  logic             CLK = 1'b0;
  logic             RST;
  logic             REQ0, WE0, REQ1, WE1;
  logic [AW-1:0]    ADDR0, ADDR1;
  logic [WIDTH-1:0] WDATA0, WDATA1;
  logic             ACK0, ACK1;
  logic [WIDTH-1:0] RDATA0, RDATA1;
  logic             RF_EN;
  logic [AW-1:0]    RF_SEL;
  logic [WIDTH-1:0] RF_IN, RF_OUT;
  logic             BUSY;

  typedef struct packed {
    logic             id;
    logic [WIDTH-1:0] r0;
    logic [WIDTH-1:0] r1;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   ack_count = 0;

  logic [WIDTH-1:0] mem [16];

  reg_f_arbiter #(.WIDTH(WIDTH), .SIZE(9)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .WE0(WE0), .ADDR0(ADDR0), .WDATA0(WDATA0), .ACK0(ACK0), .RDATA0(RDATA0),
    .REQ1(REQ1), .WE1(WE1), .ADDR1(ADDR1), .WDATA1(WDATA1), .ACK1(ACK1), .RDATA1(RDATA1),
    .RF_EN(RF_EN), .RF_SEL(RF_SEL), .RF_IN(RF_IN), .RF_OUT(RF_OUT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // reg_f model: registers are not reset, write on rising edge when EN
  assign RF_OUT = mem[RF_SEL];
  always @(posedge CLK) if (RF_EN) mem[RF_SEL] <= RF_IN;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every ACK pops the scoreboard
  always @(negedge CLK) begin
    if (!RST && (ACK0 || ACK1)) begin
      ack_count++;
      if (ACK0 && ACK1) chk("ack_both", 32'(1), 32'(0));
      if (sb.size() == 0) begin
        chk("ack_unexpected", 32'({ACK1, ACK0}), 32'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_id", 32'(ACK1), 32'(e.id));
        chk("rdata0", 32'(RDATA0), 32'(e.r0));
        chk("rdata1", 32'(RDATA1), 32'(e.r1));
      end
    end
  end

  task automatic drive(input bit id, input bit req, input bit we,
                       input logic [AW-1:0] addr, input logic [WIDTH-1:0] wd);
    if (id) begin REQ1 = req; WE1 = we; ADDR1 = addr; WDATA1 = wd; end
    else    begin REQ0 = req; WE0 = we; ADDR0 = addr; WDATA0 = wd; end
  endtask

  // One transaction; called #1 after a rising edge with the DUT in IDLE
  task automatic issue(input bit id, input bit we, input logic [AW-1:0] addr,
                       input logic [WIDTH-1:0] wd, input logic [WIDTH-1:0] e0,
                       input logic [WIDTH-1:0] e1, input bit early_drop);
    int target;
    exp_t e;
    target = ack_count + 1;
    e.id = id; e.r0 = e0; e.r1 = e1;
    sb.push_back(e);
    drive(id, 1'b1, we, addr, wd);
    @(posedge CLK); #1;
    chk("xfer_en", 32'(RF_EN), 32'(we));
    chk("xfer_sel", 32'(RF_SEL), 32'(addr));
    chk("xfer_in", 32'(RF_IN), 32'(wd));
    chk("xfer_busy", 32'(BUSY), 32'(1));
    if (early_drop) drive(id, 1'b0, we, addr, wd);
    @(posedge CLK); #1;
    chk("acks_en", 32'(RF_EN), 32'(0));
    chk("acks_busy", 32'(BUSY), 32'(1));
    @(posedge CLK); #1;
    chk("ack_seen", 32'(ack_count), 32'(target));
    chk("idle_busy", 32'(BUSY), 32'(0));
    chk("idle_sel_held", 32'(RF_SEL), 32'(addr));
    drive(id, 1'b0, we, addr, wd);
  endtask

  // Both requesters held for n transactions; BUSY low only in IDLE cycles
  task automatic contend(input int n);
    int target;
    exp_t e;
    target = ack_count + n;
    for (int i = 0; i < n; i++) begin
      e.id = 1'(i % 2); e.r0 = '0; e.r1 = '0;
      sb.push_back(e);
    end
    drive(1'b0, 1'b1, 1'b1, 4'h1, 8'h11);
    drive(1'b1, 1'b1, 1'b1, 4'h2, 8'h22);
    for (int j = 1; j <= 3 * n; j++) begin
      @(posedge CLK); #1;
      chk("contend_busy", 32'(BUSY), 32'((j % 3) != 0));
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    chk("contend_acks", 32'(ack_count), 32'(target));
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[8] = 8'h5A;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    RST = 1'b1;
    #2;
    chk("rst_en", 32'(RF_EN), 32'(0));
    chk("rst_sel", 32'(RF_SEL), 32'(0));
    chk("rst_in", 32'(RF_IN), 32'(0));
    chk("rst_ack", 32'({ACK1, ACK0}), 32'(0));
    chk("rst_rdata", 32'({RDATA1, RDATA0}), 32'(0));
    chk("rst_busy", 32'(BUSY), 32'(0));
    do_reset();

    // Write, read-back, port read/write, early drop
    issue(1'b0, 1'b1, 4'h0, 8'hDE, 8'h00, 8'h00, 1'b0);
    chk("mem0", 32'(mem[0]), 32'(8'hDE));
    issue(1'b1, 1'b0, 4'h0, 8'h00, 8'h00, 8'hDE, 1'b0);
    issue(1'b0, 1'b0, 4'h8, 8'h00, 8'h5A, 8'hDE, 1'b0);
    issue(1'b1, 1'b1, 4'hF, 8'hDC, 8'h5A, 8'hDE, 1'b0);
    chk("mem15", 32'(mem[15]), 32'(8'hDC));
    issue(1'b0, 1'b0, 4'h0, 8'h00, 8'hDE, 8'hDE, 1'b1);
    repeat (4) @(posedge CLK);
    #1;
    chk("no_retrans_busy", 32'(BUSY), 32'(0));
    chk("no_retrans_acks", 32'(ack_count), 32'(5));

    // Contention right after reset: 0,1,0,1
    do_reset();
    contend(4);
    chk("mem1", 32'(mem[1]), 32'(8'h11));
    chk("mem2", 32'(mem[2]), 32'(8'h22));

    // Leave LAST=0, then reset during XFER of a write
    issue(1'b0, 1'b1, 4'h4, 8'h44, 8'h00, 8'h00, 1'b0);
    chk("mem4", 32'(mem[4]), 32'(8'h44));
    drive(1'b0, 1'b1, 1'b1, 4'h3, 8'hAB);
    @(posedge CLK); #1;
    chk("rst_xfer_en_pre", 32'(RF_EN), 32'(1));
    #2 RST = 1'b1;
    #1;
    chk("rst_xfer_en", 32'(RF_EN), 32'(0));
    chk("rst_xfer_busy", 32'(BUSY), 32'(0));
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge CLK); #3;
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_no_ack", 32'(ack_count), 32'(10));
    chk("mem3", 32'(mem[3]), 32'(0));
    contend(2);

    chk("sb_empty", 32'(sb.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
